// File: rtl/latch_pair_monitor_pkg.sv
// latch_mon_pkg: shared state encoding, run-counter width and saturating increment for latch_pair_monitor
package latch_mon_pkg;
  typedef enum logic [1:0] {INIT = 2'b00, TRACK = 2'b01, FAULT = 2'b10} state_t;
  localparam int RUN_W = 4;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] top;
    top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= top) ? top : v + 32'd1;
  endfunction
endpackage

// File: rtl/latch_pair_monitor_if.sv
// latch_pair_monitor_if: latch rail inputs, clear and monitor status outputs
interface latch_pair_monitor_if import latch_mon_pkg::*; #(parameter int CNT_W = 8);
  logic q_in, p_in, clr;
  logic d_out, valid_out, fault;
  logic [CNT_W-1:0] rise_cnt, fall_cnt, fault_cnt;
  state_t state;
  modport master(output q_in, p_in, clr, input d_out, valid_out, rise_cnt, fall_cnt, fault, fault_cnt, state);
  modport slave(input q_in, p_in, clr, output d_out, valid_out, rise_cnt, fall_cnt, fault, fault_cnt, state);
endinterface

// File: rtl/latch_pair_monitor_sync_chain.sv
// sync_chain: STAGES-deep reset-to-0 synchroniser for one asynchronous rail
module sync_chain #(parameter int STAGES = 2) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= '0;
    else ff <= {ff[STAGES-2:0], din};
  assign dout = ff[STAGES-1];
endmodule

// File: rtl/latch_pair_monitor.sv
// latch_pair_monitor: recovers the data bit from a (q,p) latch pair, counts edges, latches illegal q==p faults
// Optional LPM_GLITCH_FILTER_EN: accept a legal pair only when it matched the previous cycle's pair
module latch_pair_monitor import latch_mon_pkg::*; #(
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 8,
  parameter int FAULT_CYCLES = 3
) (
  input logic clk,
  input logic rst_n,
  latch_pair_monitor_if.slave mon
);
  logic qs, ps, legal, accept;
  state_t st, st_n;
  logic d, d_n, valid, valid_n, fault, fault_n;
  logic [CNT_W-1:0] rise, rise_n, fall, fall_n, fcnt, fcnt_n;
  logic [RUN_W-1:0] run, run_n;
  sync_chain #(.STAGES(SYNC_STAGES)) u_sync_q (.clk(clk), .rst_n(rst_n), .din(mon.q_in), .dout(qs));
  sync_chain #(.STAGES(SYNC_STAGES)) u_sync_p (.clk(clk), .rst_n(rst_n), .din(mon.p_in), .dout(ps));
  assign legal = qs ^ ps;
`ifdef LPM_GLITCH_FILTER_EN
  logic [1:0] prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev <= '0;
    else prev <= {qs, ps};
  assign accept = legal && (prev == {qs, ps});
`else
  assign accept = legal;
`endif
  always_comb begin
    st_n    = st;
    d_n     = d;
    valid_n = 1'b0;
    rise_n  = rise;
    fall_n  = fall;
    fault_n = fault;
    fcnt_n  = fcnt;
    run_n   = run;
    if (mon.clr) begin
      st_n    = INIT;
      rise_n  = '0;
      fall_n  = '0;
      fault_n = 1'b0;
      fcnt_n  = '0;
      run_n   = '0;
    end else begin
      case (st)
        INIT: if (accept) begin
          st_n    = TRACK;
          d_n     = qs;
          valid_n = 1'b1;
        end
        TRACK: if (accept) begin
          run_n   = '0;
          valid_n = 1'b1;
          if (qs != d) begin
            d_n    = qs;
            rise_n = qs ? CNT_W'(sat_inc(32'(rise), CNT_W)) : rise;
            fall_n = qs ? fall : CNT_W'(sat_inc(32'(fall), CNT_W));
          end
        end else if (!legal) begin
          run_n = run + 1'b1;
          if (run_n >= RUN_W'(FAULT_CYCLES)) begin
            st_n    = FAULT;
            fault_n = 1'b1;
            fcnt_n  = CNT_W'(sat_inc(32'(fcnt), CNT_W));
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st    <= INIT;
      d     <= 1'b0;
      valid <= 1'b0;
      rise  <= '0;
      fall  <= '0;
      fault <= 1'b0;
      fcnt  <= '0;
      run   <= '0;
    end else begin
      st    <= st_n;
      d     <= d_n;
      valid <= valid_n;
      rise  <= rise_n;
      fall  <= fall_n;
      fault <= fault_n;
      fcnt  <= fcnt_n;
      run   <= run_n;
    end
  assign mon.state     = st;
  assign mon.d_out     = d;
  assign mon.valid_out = valid;
  assign mon.rise_cnt  = rise;
  assign mon.fall_cnt  = fall;
  assign mon.fault     = fault;
  assign mon.fault_cnt = fcnt;
endmodule

// File: doc/latch_pair_monitor.md
Name: latch_pair_monitor

Overview:
- Downstream consumer of the gated SR/D latch dataflow cell's complementary output pair (q, p).
- Synchronises both rails into the monitor clock domain and recovers the stored data bit.
- Counts rising and falling data transitions; detects the illegal q==p condition and latches a fault.
- Sits between the latch cell and the bench scoreboard/status logic.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchroniser on each rail (legal range 2..4)
CNT_W, 8, width of the rise, fall and fault counters
FAULT_CYCLES, 3, consecutive synchronised q==p samples required to declare a fault (legal range 1..15)

Ports:
clk  in  1  monitor clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
q_in  in  1  latch q rail (asynchronous to clk)
p_in  in  1  latch p rail (asynchronous to clk)
clr  in  1  synchronous clear of counters, fault and FSM
d_out  out  1  last valid recovered data bit (= synchronised q when q!=p)
valid_out  out  1  high while the current synchronised pair is legal (q!=p) and FSM is not in INIT
rise_cnt  out  CNT_W  count of accepted 0->1 data transitions, saturating
fall_cnt  out  CNT_W  count of accepted 1->0 data transitions, saturating
fault  out  1  sticky illegal-state flag
fault_cnt  out  CNT_W  number of fault entries, saturating
state  out  2  FSM state: INIT=00, TRACK=01, FAULT=10

Behaviour:
- Reset (rst_n low, asynchronous): all synchroniser flops, d_out, valid_out, the three counters, fault and the run counter clear to 0; state=INIT.
- Each rail passes through its own SYNC_STAGES-deep flop chain to give qs/ps. A sample is legal when qs!=ps.
- INIT:
  - First legal sample: load d_out=qs, go to TRACK. No edge is counted.
  - Illegal samples: stay in INIT; they do not count toward a fault.
- TRACK, legal sample:
  - Clear the run counter.
  - If qs!=d_out: update d_out and increment rise_cnt (qs=1) or fall_cnt (qs=0).
- TRACK, illegal sample:
  - Increment the run counter; d_out holds.
  - When run reaches FAULT_CYCLES: go to FAULT, set fault=1, increment fault_cnt.
- FAULT: sticky. Ignores all samples, counters freeze, d_out holds. Exits only via clr or reset.
- clr:
  - Next edge: counters, fault and the run counter go to 0; state=INIT; d_out holds.
  - clr takes priority over any same-cycle sample event.
- valid_out is registered: 1 in TRACK when the sample just processed was legal, else 0.
- Latency: a q_in/p_in toggle reaches d_out and the counters SYNC_STAGES+1 clk edges later.
- Counters saturate at all-ones and never wrap.
- Run counter width: 4 bits.

Optional Feature:
- Macro LPM_GLITCH_FILTER_EN.
- Defined: a legal sample is accepted only if the identical (qs,ps) pair was present on the previous cycle. A single-cycle pulse is ignored; it neither updates d_out nor counts as an edge, and it does not clear the run counter. Latency becomes SYNC_STAGES+2 edges. Illegal-sample fault counting is unchanged.
- Undefined: behaviour exactly as above.

Decomposition:
- Package latch_mon_pkg holds:
  - state typedef with encodings INIT=2'b00, TRACK=2'b01, FAULT=2'b10;
  - the run-counter width constant (4);
  - the saturating-increment function.
- Sub-module sync_chain (parameter STAGES, 1-bit input, reset-to-0) is instantiated once per rail.

Test Plan:
- Reset with q_in=1, p_in=0, then release: state=INIT. After 3 edges: state=TRACK, d_out=1, rise_cnt=0, valid_out=1.
- Drive the pair 10->01->10->01 with each value held 10 cycles: rise_cnt=1, fall_cnt=2, fault=0, and each d_out change lands 3 edges after its input toggle.
- From TRACK, hold q_in=p_in=1: after 2 samples state=TRACK. On the 3rd: state=FAULT, fault=1, fault_cnt=1. Then restore 10: state stays FAULT, counters frozen.
- Illegal pulse of 2 sampled cycles followed by legal 01: no fault and the run counter clears. Assert clr while a legal edge arrives: counters=0, state=INIT, edge not counted.
- Force 300 accepted rises with CNT_W=8: rise_cnt holds at 255. Assert rst_n low mid-run: all outputs 0 immediately, without waiting for a clk edge.
- With LPM_GLITCH_FILTER_EN: a 1-cycle 01 glitch in a 10 stream leaves fall_cnt unchanged. A 2-cycle 01 causes fall_cnt+1 at SYNC_STAGES+2 edges.
